// File: rtl/erx_decoder.sv
// elink receive frame decoder: 4 byte pairs per cycle -> 104-bit emesh packets,
// with a one-entry hold buffer. Define ERX_DECODER_CHECK_EN for truncation errors.
module erx_decoder #(
    parameter int PW = 104
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [63:0]   rx_data_slow,
    input  logic [3:0]    rx_frame_slow,
    output logic          rx_access,
    output logic [PW-1:0] rx_packet,
    input  logic          rx_wait,
    output logic          rx_wait_out,
    output logic          rx_overflow,
    output logic          rx_frame_err,
    input  logic          err_clear
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          r_state, w_state;
    logic [2:0]      r_cnt, w_cnt;
    logic [PW-1:0]   r_asm, w_asm;
    logic            r_prev, w_prev;
    logic            w_done;
    logic [PW-1:0]   w_pkt;
`ifdef ERX_DECODER_CHECK_EN
    logic            w_trunc;
    logic            r_frame_err;
`endif

    logic            r_out_vld, r_hold_vld, r_ovf;
    logic [PW-1:0]   r_out, r_hold;
    logic            w_consume, w_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_asm   <= w_asm;
            r_prev  <= w_prev;
        end
    end

    // Walk the four pairs in arrival order; the assembly register is filled
    // field by field so the completed packet is ready at pair 7 (pad pair).
    always_comb begin
        logic        f;
        logic        fin;
        logic [15:0] pair;
        f       = 1'b0;
        fin     = 1'b0;
        pair    = '0;
        w_state = r_state;
        w_cnt   = r_cnt;
        w_asm   = r_asm;
        w_prev  = r_prev;
        w_done  = 1'b0;
        w_pkt   = r_asm;
`ifdef ERX_DECODER_CHECK_EN
        w_trunc = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            f    = rx_frame_slow[3-k];
            pair = rx_data_slow[63-16*k -: 16];
            fin  = 1'b0;
            if (w_state == COLLECT && !f) begin
                w_state = IDLE;
                w_cnt   = '0;
`ifdef ERX_DECODER_CHECK_EN
                w_trunc = 1'b1;
`endif
            end else if (w_state == IDLE && f && !w_prev) begin
                w_state = COLLECT;
                w_cnt   = '0;
            end
            if (w_state == COLLECT) begin
                case (w_cnt)
                    3'd0: begin
                        w_asm[0]   = pair[9];
                        w_asm[2:1] = pair[11:10];
                        w_asm[6:3] = pair[15:12];
                        w_asm[7]   = pair[0];
                    end
                    3'd1: w_asm[39:24]  = pair;
                    3'd2: w_asm[23:8]   = pair;
                    3'd3: w_asm[71:56]  = pair;
                    3'd4: w_asm[55:40]  = pair;
                    3'd5: w_asm[103:88] = pair;
                    3'd6: w_asm[87:72]  = pair;
                    default: begin
                        w_done = 1'b1;
                        w_pkt  = w_asm;
                        fin    = 1'b1;
                    end
                endcase
                if (w_cnt == 3'd7) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = w_cnt + 3'd1;
                end
            end
            // A completed packet makes a still-high frame look like a fresh start.
            w_prev = f && !fin;
        end
    end

    assign w_consume = r_out_vld && !rx_wait;
    assign w_ovf     = w_done && r_out_vld && !w_consume && r_hold_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_vld  <= 1'b0;
            r_out      <= '0;
            r_hold_vld <= 1'b0;
            r_hold     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_consume) begin
                if (r_hold_vld) begin
                    r_out      <= r_hold;
                    r_hold_vld <= w_done;
                    if (w_done) r_hold <= w_pkt;
                end else begin
                    r_out_vld <= w_done;
                    if (w_done) r_out <= w_pkt;
                end
            end else if (w_done) begin
                if (!r_out_vld) begin
                    r_out_vld <= 1'b1;
                    r_out     <= w_pkt;
                end else if (!r_hold_vld) begin
                    r_hold_vld <= 1'b1;
                    r_hold     <= w_pkt;
                end
            end
            if (err_clear)  r_ovf <= 1'b0;
            else if (w_ovf) r_ovf <= 1'b1;
        end
    end

`ifdef ERX_DECODER_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_frame_err <= 1'b0;
        else if (err_clear) r_frame_err <= 1'b0;
        else if (w_trunc)   r_frame_err <= 1'b1;
    end
    assign rx_frame_err = r_frame_err;
`else
    assign rx_frame_err = 1'b0;
`endif

    assign rx_access   = r_out_vld;
    assign rx_packet   = r_out;
    assign rx_wait_out = r_hold_vld;
    assign rx_overflow = r_ovf;

endmodule

// File: doc/erx_decoder.md
# erx_decoder

Receive-side frame decoder for the elink. It sits in the receive path after the IO deserializer and runs in the lclk_div4 domain. It accepts 8 bytes and 4 frame bits per cycle, finds packet starts at any byte-pair alignment, and assembles 16-byte wire packets into emesh packets. It buffers one extra packet under downstream wait and flags overflow and truncated frames.

## Interface
- PW, 104, emesh packet width (fixed layout below)
- clk, input, 1, rx_lclk_div4; all logic on rising edge
- reset, input, 1, asynchronous, active-high; clears all state
- rx_data_slow, input, 64, 8 wire bytes per cycle
- rx_frame_slow, input, 4, one frame bit per byte pair
- rx_access, output, 1, packet valid
- rx_packet, output, PW, {srcaddr[31:0], data[31:0], dstaddr[31:0], ctrlmode[4:0], datamode[1:0], write}
- rx_wait, input, 1, downstream stall
- rx_wait_out, output, 1, pushback to link; high while the hold buffer is occupied
- rx_overflow, output, 1, sticky: a packet was dropped
- rx_frame_err, output, 1, sticky: a truncated packet was seen
- err_clear, input, 1, synchronous clear of both sticky flags

## Operation
- Pair k (k=0..3, earliest first) is rx_data_slow[63-16k -: 16], with the earlier byte in the upper half. Its frame bit is rx_frame_slow[3-k].
- Wire packet is 8 pairs (bytes B0..B15):
  - B0 = {ctrlmode[3:0], datamode[1:0], write, 1'b0}
  - B1 = {7'b0, ctrlmode[4]}
  - B2-B5 = dstaddr, MSB first
  - B6-B9 = data, MSB first
  - B10-B13 = srcaddr, MSB first
  - B14-B15 = pad, ignored
- Start condition: a pair whose frame=1 when the previous pair (including pair 3 of the prior cycle) had frame=0. A frame that stays high after pair 8 completes also starts the next packet (back-to-back).
- States:
  - IDLE: no packet in progress.
  - COLLECT: pair counter 0..7.
  - Transitions: IDLE to COLLECT on start. COLLECT to IDLE at pair 8 if frame is low next, otherwise restart at count 0.
  - Completion and a new start can occur in the same cycle. At most one completion occurs per cycle.
- Truncation: frame drops while count<8. The partial packet is discarded, rx_frame_err is set (see Configuration), and the FSM returns to IDLE.
- Output stage:
  - Output register plus a one-entry hold buffer.
  - A completed packet goes to the output register if it is empty or being consumed, otherwise to the hold buffer.
  - If both are full, the packet is dropped and rx_overflow is set.
- A packet is consumed in any cycle with rx_access=1 and rx_wait=0. The hold buffer refills the output register in that same cycle.
- err_clear has priority over a set event in the same cycle.

## Timing
- Reset values: rx_access=0, rx_packet=0, rx_wait_out=0, rx_overflow=0, rx_frame_err=0, FSM=IDLE, count=0, hold buffer empty. The prior-pair frame history resets to 0.
- Latency: last pair (B14-B15) sampled in cycle N gives rx_access=1 in cycle N+1 when the output is free.
- Throughput: one packet per 2 cycles at full rate with a continuous frame.
- rx_packet is stable while rx_access=1 and rx_wait=1.
- rx_wait_out rises the cycle after the hold buffer fills. It falls the cycle after the hold buffer drains.
- Reset asserted mid-packet: partial data is lost. No output follows reset release until a new start.
- Aligned start (pair 0) spans 2 cycles. A start at pair 1-3 spans 3 cycles.

## Configuration
- ERX_DECODER_CHECK_EN defined: truncation detection is active, rx_frame_err behaves as specified, and truncated packets are discarded.
- Not defined: rx_frame_err is tied to 0. A frame drop still returns the FSM to IDLE and silently discards the partial packet. No error logic is synthesized.

## Test plan
- Aligned packet: frame=4'b1111 for 2 cycles, then 0; bytes dstaddr=0x80800000, data=0xDEADBEEF, srcaddr=0x12345678, write=1, datamode=2. Required: one rx_access pulse 1 cycle after the second word, with rx_packet[0]=1, [2:1]=2, [39:8]=0x80800000, [71:40]=0xDEADBEEF, [103:72]=0x12345678.
- Misaligned: frame=4'b0011, 4'b1111, 4'b1100 with the same payload. Required: identical rx_packet, rx_access in the cycle after the third word.
- Back-to-back: frame high for 4 cycles with two packets. Required: two rx_access pulses 2 cycles apart, correct payloads, no errors.
- Truncation: frame high for 5 pairs only, with the CHECK macro defined. Required: no rx_access and rx_frame_err=1. err_clear=1 returns it to 0 the next cycle.
- Wait and overflow: rx_wait=1 held while 3 packets arrive. Required: packet 1 held on the output; rx_wait_out=1 after packet 2; packet 3 dropped with rx_overflow=1. After rx_wait=0, packets 1 and 2 are delivered on consecutive cycles.
- Async reset mid-COLLECT: reset pulse after 3 pairs. Required: all outputs 0 immediately; the next full packet decodes correctly.
